fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_BITS, default 10: width of every data word.
REQ-002 SHALL have parameter CNT_BITS, default 16: width of the delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; 1 permits new FIFO reads.
REQ-006 SHALL have port fifo_data_in  input  DATA_BITS  read data from the FIFO, valid one cycle after fifo_read.
REQ-007 SHALL have port fifo_empty_in  input  1  FIFO empty flag, pointer-based, current cycle.
REQ-008 SHALL have port error_fifo_in  input  1  sticky FIFO overflow/underflow error.
REQ-009 SHALL have port fifo_read  output  1  pop request to the FIFO, one word per asserted cycle.
REQ-010 SHALL have port data_out  output  DATA_BITS  head word presented downstream.
REQ-011 SHALL have port valid_out  output  1  data_out holds a word.
REQ-012 SHALL have port ready_in  input  1  downstream accepts; a transfer occurs when valid_out and ready_in are both 1.
REQ-013 SHALL have port halted_out  output  1  1 while the state machine is in HALT.

Function
REQ-014 SHALL contain a 2-entry skid buffer (occ 0..2) plus an in-flight flag (infl 0..1) for the one-cycle FIFO read latency.
REQ-015 SHALL assert fifo_read combinationally iff state==RUN, fifo_empty_in==0, and occ+infl-pop<2, where pop = valid_out&&ready_in.
REQ-016 SHALL set infl<=fifo_read every cycle, and write fifo_data_in into the buffer tail on the edge where infl==1.
REQ-017 SHALL drive valid_out=(occ!=0) and data_out=head entry; data_out SHALL hold stable while valid_out=1 and ready_in=0.
REQ-018 SHALL, on simultaneous capture and pop, move the second entry to head, append the new word, and leave occ unchanged; order SHALL be strictly FIFO.
REQ-019 SHALL sustain one transfer per cycle when ready_in=1 and the FIFO is non-empty.
REQ-020 SHALL implement states IDLE, RUN and HALT.
REQ-021 SHALL transition IDLE->RUN when enable=1.
REQ-022 SHALL transition RUN->IDLE when enable=0.
REQ-023 SHALL transition any->HALT when error_fifo_in=1; HALT SHALL be left only by reset.
REQ-024 SHALL, after leaving RUN, still capture an in-flight word and drain buffered words downstream; fifo_read SHALL be 0.
REQ-025 SHALL never assert fifo_read while fifo_empty_in=1, so it never underflows the FIFO.
REQ-026 SHALL drive halted_out=1 in HALT and 0 otherwise.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, occ=0, infl=0, fifo_read=0, valid_out=0, data_out=0, halted_out=0 and counter=0, independent of clk.
REQ-028 SHALL discard buffered and in-flight words on reset mid-operation; the first post-reset transfer SHALL come from a new read.

Configuration
REQ-029 SHALL, with FIFO_READER_STATS_EN defined, add output word_count (CNT_BITS), incremented by 1 per downstream transfer, wrapping 2^CNT_BITS-1->0, reset to 0.
REQ-030 SHALL, without FIFO_READER_STATS_EN defined, omit the word_count port and the counter; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take its state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2) and the DATA_BITS default from the shared fifo_pkg package, the same package used by the FIFO.
REQ-032 SHALL place the 2-entry skid buffer in sub-module skid_buf2; the state machine and fifo_read issue logic SHALL stay in fifo_reader.

Verification
REQ-033 SHALL verify: FIFO preloaded with 0x001..0x005, enable=1, ready_in=1 -> fifo_read high 5 consecutive cycles, data_out 0x001..0x005 on consecutive cycles, then valid_out=0.
REQ-034 SHALL verify: 3 words queued, ready_in=0 -> exactly 2 reads, valid_out=1, data_out=0x001 held; ready_in=1 -> 0x001, 0x002, 0x003 in order with no loss.
REQ-035 SHALL verify: FIFO empty, enable=1 -> fifo_read never asserts; one word written -> one read, valid_out rises exactly 2 cycles after the write.
REQ-036 SHALL verify: error_fifo_in pulsed in RUN -> halted_out=1 next cycle, fifo_read=0 thereafter, buffered words still drain, and the state stays HALT until reset.
REQ-037 SHALL verify: reset asserted between clk edges with occ=2 -> valid_out=0 and fifo_read=0 immediately, with no clock edge needed.
REQ-038 SHALL verify: with FIFO_READER_STATS_EN and CNT_BITS=4, 17 transfers -> word_count=1 after wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: reader state encoding, default data width and the
// read-issue credit check used by fifo_reader.
package fifo_pkg;

    localparam int DATA_BITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // A new read may issue only if the word it returns is guaranteed a buffer slot.
    function automatic logic can_issue(input logic [1:0] occ, input logic infl, input logic pop);
        return ({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is the head presented downstream.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 pop,
    output logic [1:0]           occ,
    output logic [DATA_BITS-1:0] head_data,
    output logic                 valid
);

    logic [DATA_BITS-1:0] entry_reg [2];
    logic [DATA_BITS-1:0] entry_next [2];
    logic [1:0]           occ_reg;
    logic [1:0]           occ_next;
    logic [1:0]           base;
    logic                 pop_ok;
    logic                 wr_ok;

    always_comb begin
        pop_ok = pop && (occ_reg != 2'd0);
        // base is the occupancy after the pop, i.e. the slot a new word lands in
        base   = occ_reg - {1'b0, pop_ok};
        wr_ok  = wr_en && !base[1];
        occ_next = base + {1'b0, wr_ok};

        entry_next[0] = pop_ok ? entry_reg[1] : entry_reg[0];
        entry_next[1] = entry_reg[1];
        if (wr_ok) begin
            entry_next[base[0]] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_reg      <= 2'd0;
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
        end else begin
            occ_reg      <= occ_next;
            entry_reg[0] <= entry_next[0];
            entry_reg[1] <= entry_next[1];
        end
    end

    assign occ       = occ_reg;
    assign valid     = (occ_reg != 2'd0);
    assign head_data = entry_reg[0];

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a one-cycle-latency FIFO into a skid buffer and streams them
// downstream with valid/ready. Define FIFO_READER_STATS_EN to add word_count.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 fifo_empty_in,
    input  logic                 error_fifo_in,
    output logic                 fifo_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 halted_out
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_BITS-1:0]  word_count
`endif
);

    state_t     state_reg;
    state_t     state_next;
    logic       infl_reg;
    logic [1:0] occ;
    logic       pop;

    assign pop = valid_out && ready_in;

    always_comb begin
        state_next = state_reg;
        fifo_read  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) state_next = IDLE;
                fifo_read = !fifo_empty_in && can_issue(occ, infl_reg, pop);
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (error_fifo_in) state_next = HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            infl_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            infl_reg  <= fifo_read;
        end
    end

    assign halted_out = (state_reg == HALT);

    // The word requested last cycle is on fifo_data_in now; capture it even after leaving RUN.
    skid_buf2 #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (infl_reg),
        .wr_data   (fifo_data_in),
        .pop       (pop),
        .occ       (occ),
        .head_data (data_out),
        .valid     (valid_out)
    );

`ifdef FIFO_READER_STATS_EN
    logic [CNT_BITS-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + CNT_BITS'(1);
        end
    end

    assign word_count = count_reg;
`else
    // Keeps CNT_BITS referenced when statistics are compiled out.
    logic [CNT_BITS-1:0] unused_cnt_width;
    assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed bench for fifo_reader with a queue-based FIFO model
// and an in-order scoreboard of every word popped from that FIFO.
module tb_fifo_reader;

    localparam int DW = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_empty_in;
    logic          error_fifo_in;
    logic          ready_in;
    logic          fifo_read;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          halted_out;
`ifdef FIFO_READER_STATS_EN
    logic [CW-1:0] word_count;
`endif

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_BITS (DW),
        .CNT_BITS  (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_data_in  (fifo_data_in),
        .fifo_empty_in (fifo_empty_in),
        .error_fifo_in (error_fifo_in),
        .fifo_read     (fifo_read),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .halted_out    (halted_out)
`ifdef FIFO_READER_STATS_EN
        ,
        .word_count    (word_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int underflow_cnt = 0;
    int reads_cnt = 0;
    int xfer_cnt = 0;

    logic          s_read, s_valid, s_ready, s_halt;
    logic [DW-1:0] s_data;
    logic          last_xfer, last_bad;
    logic [DW-1:0] last_data, last_exp;

    // One clock: sample outputs at the falling edge, then apply the FIFO's response.
    task automatic cycle();
        @(negedge clk);
        s_read  = fifo_read;
        s_valid = valid_out;
        s_ready = ready_in;
        s_data  = data_out;
        s_halt  = halted_out;
        @(posedge clk);
        #1;
        last_xfer = s_valid && s_ready;
        last_data = s_data;
        last_exp  = '0;
        last_bad  = 1'b0;
        if (last_xfer) begin
            xfer_cnt++;
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                last_bad = (last_data !== last_exp);
            end else begin
                last_bad = 1'b1;
            end
        end
        if (s_read) begin
            reads_cnt++;
            if (fq.size() == 0) begin
                underflow_cnt++;
            end else begin
                fifo_data_in = fq.pop_front();
                exp_q.push_back(fifo_data_in);
            end
        end else begin
            fifo_data_in = DW'($urandom);
        end
        fifo_empty_in = (fq.size() == 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        enable = 1'b0;
        ready_in = 1'b0;
        error_fifo_in = 1'b0;
        fq.delete();
        exp_q.delete();
        fifo_empty_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; ready_in = 1'b1; error_fifo_in = 1'b0;
        fifo_data_in = '0;
        fq.push_back(10'h3C3);
        fifo_empty_in = 1'b0;
        #2;
        n_cmp++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", fifo_read); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 000", data_out); end
        n_cmp++; if (halted_out !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b want 0", halted_out); end
`ifdef FIFO_READER_STATS_EN
        n_cmp++; if (word_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", word_count); end
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (fifo_read !== 1'b0 || valid_out !== 1'b0) begin
            n_err++; $display("FAIL reset_held: read %b valid %b want 0 0", fifo_read, valid_out);
        end
        $display("test_reset done");
    endtask

    task automatic test_burst();
        int first_rd, last_rd, nrd, first_x, last_x;
        logic [DW-1:0] got[$];
        apply_reset();
        for (int w = 1; w <= 5; w++) fq.push_back(DW'(w));
        fifo_empty_in = 1'b0;
        enable = 1'b1;
        ready_in = 1'b1;
        first_rd = -1; last_rd = -1; nrd = 0; first_x = -1; last_x = -1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (s_read) begin nrd++; if (first_rd < 0) first_rd = c; last_rd = c; end
            if (last_xfer) begin got.push_back(last_data); if (first_x < 0) first_x = c; last_x = c; end
        end
        n_cmp++; if (nrd != 5 || last_rd - first_rd != 4) begin
            n_err++; $display("FAIL burst_reads: got %0d reads over span %0d want 5 over 4", nrd, last_rd - first_rd);
        end
        n_cmp++; if (got.size() != 5 || last_x - first_x != 4) begin
            n_err++; $display("FAIL burst_xfers: got %0d over span %0d want 5 over 4", got.size(), last_x - first_x);
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_cmp++; if (got[i] !== DW'(i + 1)) begin n_err++; $display("FAIL burst_data[%0d]: got %h want %h", i, got[i], DW'(i + 1)); end
        end
        n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL burst_end_valid: got %b want 0", s_valid); end
        $display("test_burst done: %0d reads, %0d transfers", nrd, got.size());
    endtask

    task automatic test_backpressure();
        int rd0;
        logic [DW-1:0] got[$];
        apply_reset();
        for (int w = 1; w <= 3; w++) fq.push_back(DW'(w));
        fifo_empty_in = 1'b0;
        enable = 1'b1;
        ready_in = 1'b0;
        rd0 = reads_cnt;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (s_valid) begin
                n_cmp++; if (s_data !== DW'(1)) begin n_err++; $display("FAIL bp_hold: got %h want 001", s_data); end
            end
        end
        n_cmp++; if (reads_cnt - rd0 != 2) begin n_err++; $display("FAIL bp_reads: got %0d want 2", reads_cnt - rd0); end
        n_cmp++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", s_valid); end
        ready_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_xfer) got.push_back(last_data);
        end
        n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_cmp++; if (got[i] !== DW'(i + 1)) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], DW'(i + 1)); end
        end
        $display("test_backpressure done: %0d words delivered", got.size());
    endtask

    task automatic test_empty();
        int rd0, rise;
        apply_reset();
        enable = 1'b1;
        ready_in = 1'b1;
        rd0 = reads_cnt;
        for (int c = 0; c < 6; c++) cycle();
        n_cmp++; if (reads_cnt != rd0 || underflow_cnt != 0) begin
            n_err++; $display("FAIL empty_reads: got %0d reads want 0", reads_cnt - rd0);
        end
        fq.push_back(10'h155);
        fifo_empty_in = 1'b0;
        rd0 = reads_cnt;
        rise = -1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (s_valid && rise < 0) rise = c;
            if (last_xfer) begin
                n_cmp++; if (last_data !== 10'h155) begin n_err++; $display("FAIL empty_word: got %h want 155", last_data); end
            end
        end
        n_cmp++; if (reads_cnt - rd0 != 1) begin n_err++; $display("FAIL empty_one_read: got %0d want 1", reads_cnt - rd0); end
        n_cmp++; if (rise != 2) begin n_err++; $display("FAIL empty_latency: got %0d cycles want 2", rise); end
        $display("test_empty done: valid after %0d cycles", rise);
    endtask

    task automatic test_halt();
        int rd0;
        apply_reset();
        for (int w = 0; w < 8; w++) fq.push_back(DW'($urandom));
        fifo_empty_in = 1'b0;
        enable = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (last_xfer) begin n_cmp++; if (last_bad) begin n_err++; $display("FAIL halt_pre_data: got %h want %h", last_data, last_exp); end end
        end
        ready_in = 1'b0;
        error_fifo_in = 1'b1;
        cycle();
        error_fifo_in = 1'b0;
        rd0 = reads_cnt;
        for (int c = 0; c < 14; c++) begin
            if (c == 5) enable = 1'b0;
            if (c == 7) enable = 1'b1;
            ready_in = (c > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c > 10) ready_in = 1'b1;
            cycle();
            n_cmp++; if (s_halt !== 1'b1) begin n_err++; $display("FAIL halt_flag[%0d]: got %b want 1", c, s_halt); end
            if (last_xfer) begin n_cmp++; if (last_bad) begin n_err++; $display("FAIL halt_drain: got %h want %h", last_data, last_exp); end end
        end
        n_cmp++; if (reads_cnt != rd0) begin n_err++; $display("FAIL halt_reads: got %0d want 0", reads_cnt - rd0); end
        n_cmp++; if (exp_q.size() != 0 || s_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_drained: %0d words left, valid %b, want 0 and 0", exp_q.size(), s_valid);
        end
        apply_reset();
        n_cmp++; if (halted_out !== 1'b0) begin n_err++; $display("FAIL halt_exit: got %b want 0", halted_out); end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid();
        int rd0, nx;
        apply_reset();
        for (int w = 1; w <= 4; w++) fq.push_back(DW'(12'h100 + w));
        fifo_empty_in = 1'b0;
        enable = 1'b1;
        ready_in = 1'b0;
        rd0 = reads_cnt;
        for (int c = 0; c < 5; c++) cycle();
        n_cmp++; if (reads_cnt - rd0 != 2 || valid_out !== 1'b1) begin
            n_err++; $display("FAIL rmid_fill: reads %0d valid %b want 2 1", reads_cnt - rd0, valid_out);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0 || fifo_read !== 1'b0 || data_out !== '0) begin
            n_err++; $display("FAIL rmid_async: valid %b read %b data %h want 0 0 000", valid_out, fifo_read, data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        fq.delete();
        fq.push_back(10'h2AA);
        fifo_empty_in = 1'b0;
        ready_in = 1'b1;
        nx = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_xfer) begin
                nx++;
                n_cmp++; if (last_data !== 10'h2AA) begin n_err++; $display("FAIL rmid_first: got %h want 2aa", last_data); end
            end
        end
        n_cmp++; if (nx != 1) begin n_err++; $display("FAIL rmid_count: got %0d want 1", nx); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic          prev_v, prev_r;
        logic [DW-1:0] prev_d;
        int            nx0;
        apply_reset();
        enable = 1'b1;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        nx0 = xfer_cnt;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) fq.push_back(DW'($urandom));
            fifo_empty_in = (fq.size() == 0);
            ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) enable = ~enable;
            cycle();
            if (last_xfer) begin n_cmp++; if (last_bad) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", c, last_data, last_exp); end end
            if (prev_v && !prev_r) begin
                n_cmp++; if (s_valid !== 1'b1 || s_data !== prev_d) begin
                    n_err++; $display("FAIL rand_stable[%0d]: valid %b data %h want 1 %h", c, s_valid, s_data, prev_d);
                end
            end
            prev_v = s_valid; prev_r = s_ready; prev_d = s_data;
        end
        enable = 1'b0;
        ready_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_xfer) begin n_cmp++; if (last_bad) begin n_err++; $display("FAIL rand_drain: got %h want %h", last_data, last_exp); end end
        end
        n_cmp++; if (exp_q.size() != 0 || s_valid !== 1'b0) begin
            n_err++; $display("FAIL rand_lost: %0d words undelivered, valid %b, want 0 and 0", exp_q.size(), s_valid);
        end
        n_cmp++; if (underflow_cnt != 0) begin n_err++; $display("FAIL underflow: got %0d reads while empty want 0", underflow_cnt); end
        $display("test_random done: %0d transfers", xfer_cnt - nx0);
    endtask

`ifdef FIFO_READER_STATS_EN
    task automatic test_stats();
        int nx0, nx;
        apply_reset();
        n_cmp++; if (word_count !== '0) begin n_err++; $display("FAIL stats_reset: got %0d want 0", word_count); end
        for (int w = 0; w < 17; w++) fq.push_back(DW'(w + 3));
        fifo_empty_in = 1'b0;
        enable = 1'b1;
        ready_in = 1'b1;
        nx0 = xfer_cnt;
        for (int c = 0; c < 25; c++) cycle();
        nx = xfer_cnt - nx0;
        n_cmp++; if (nx != 17) begin n_err++; $display("FAIL stats_xfers: got %0d want 17", nx); end
        n_cmp++; if (word_count !== CW'(nx % (1 << CW))) begin
            n_err++; $display("FAIL stats_wrap: got %0d want %0d", word_count, nx % (1 << CW));
        end
        $display("test_stats done: word_count %0d", word_count);
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_empty();
        test_halt();
        test_reset_mid();
        test_random();
`ifdef FIFO_READER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
